// File: rtl/usart_rx_fifo_if.sv
// Receiver-side bundle: serial line, enable, CPU pop handshake and status flags.
interface usart_rx_fifo_if #(
  parameter int DATA_W = 32
);
  logic              habilitar;
  logic              Rx;
  logic [DATA_W-1:0] dado;
  logic              dado_pronto;
  logic              dado_lido;
  logic              ocupado;
  logic              erro_quadro;
  logic              overrun;
  logic              erro_paridade;

  modport slave (
    input  habilitar, Rx, dado_lido,
    output dado, dado_pronto, ocupado, erro_quadro, overrun, erro_paridade
  );

  modport master (
    output habilitar, Rx, dado_lido,
    input  dado, dado_pronto, ocupado, erro_quadro, overrun, erro_paridade
  );
endinterface

// File: rtl/usart_rx_fifo.sv
// Mid-bit sampling serial receiver feeding a show-ahead FIFO; word visible the cycle after the stop sample.
// Optional even-parity bit enabled by defining USART_RX_PARIDADE_EN.
module usart_rx_fifo #(
  parameter int DATA_W       = 32,
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic            clk,
  input  logic            rst,
  usart_rx_fifo_if.slave  bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNTF_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_W - 1);
  localparam logic [CNTF_W-1:0] FULL_CNT  = CNTF_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic                              rx_meta_q, rx_meta_d;
  logic                              rx_s_q, rx_s_d;
  state_t                            state_q, state_d;
  logic [CNT_W-1:0]                  clk_cnt_q, clk_cnt_d;
  logic [IDX_W-1:0]                  bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0]                 shift_q, shift_d;
  logic                              erro_quadro_q, erro_quadro_d;
  logic                              erro_paridade_q, erro_paridade_d;
  logic                              overrun_q, overrun_d;
  logic [FIFO_DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]                  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]                  wr_ptr_q, wr_ptr_d;
  logic [CNTF_W-1:0]                 count_q, count_d;
`ifdef USART_RX_PARIDADE_EN
  logic                              par_bad_q, par_bad_d;
`endif

  logic push;
  logic pop;
  logic push_ok;
  logic fifo_full;
  logic fifo_empty;

  // Receive FSM: every state counts clk_cnt up and acts on its last count.
  always_comb begin
    rx_meta_d       = bus.Rx;
    rx_s_d          = rx_meta_q;
    state_d         = state_q;
    clk_cnt_d       = clk_cnt_q + 1'b1;
    bit_idx_d       = bit_idx_q;
    shift_d         = shift_q;
    erro_quadro_d   = 1'b0;
    erro_paridade_d = 1'b0;
    push            = 1'b0;
`ifdef USART_RX_PARIDADE_EN
    par_bad_d       = par_bad_q;
`endif

    case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        bit_idx_d = '0;
        if (bus.habilitar && !rx_s_q) begin
          state_d = S_START;
        end
      end
      S_START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          shift_d   = '0;
          state_d   = rx_s_q ? S_IDLE : S_DATA;
`ifdef USART_RX_PARIDADE_EN
          par_bad_d = 1'b0;
`endif
        end
      end
      S_DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d          = '0;
          shift_d[bit_idx_q] = rx_s_q;
          bit_idx_d          = bit_idx_q + 1'b1;
          if (bit_idx_q == IDX_LAST) begin
            bit_idx_d = '0;
`ifdef USART_RX_PARIDADE_EN
            state_d   = S_PARITY;
`else
            state_d   = S_STOP;
`endif
          end
        end
      end
`ifdef USART_RX_PARIDADE_EN
      S_PARITY: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          par_bad_d = (^shift_q) ^ rx_s_q;
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d     = '0;
          state_d       = S_IDLE;
          erro_quadro_d = !rx_s_q;
`ifdef USART_RX_PARIDADE_EN
          erro_paridade_d = par_bad_q;
          push            = rx_s_q && !par_bad_q;
`else
          push            = rx_s_q;
`endif
        end
      end
      default: begin
        state_d   = S_IDLE;
        clk_cnt_d = '0;
      end
    endcase

    // Dropping the enable abandons any partial frame silently.
    if (!bus.habilitar && (state_q != S_IDLE)) begin
      state_d         = S_IDLE;
      clk_cnt_d       = '0;
      bit_idx_d       = '0;
      push            = 1'b0;
      erro_quadro_d   = 1'b0;
      erro_paridade_d = 1'b0;
    end
  end

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign pop        = !fifo_empty && bus.dado_lido;
  assign push_ok    = push && (!fifo_full || pop);

  always_comb begin
    mem_d     = mem_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;

    if (push_ok) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (push && !push_ok) begin
      overrun_d = 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q       <= 1'b1;
      rx_s_q          <= 1'b1;
      state_q         <= S_IDLE;
      clk_cnt_q       <= '0;
      bit_idx_q       <= '0;
      shift_q         <= '0;
      erro_quadro_q   <= 1'b0;
      erro_paridade_q <= 1'b0;
      overrun_q       <= 1'b0;
      mem_q           <= '0;
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      count_q         <= '0;
`ifdef USART_RX_PARIDADE_EN
      par_bad_q       <= 1'b0;
`endif
    end else begin
      rx_meta_q       <= rx_meta_d;
      rx_s_q          <= rx_s_d;
      state_q         <= state_d;
      clk_cnt_q       <= clk_cnt_d;
      bit_idx_q       <= bit_idx_d;
      shift_q         <= shift_d;
      erro_quadro_q   <= erro_quadro_d;
      erro_paridade_q <= erro_paridade_d;
      overrun_q       <= overrun_d;
      mem_q           <= mem_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
`ifdef USART_RX_PARIDADE_EN
      par_bad_q       <= par_bad_d;
`endif
    end
  end

  assign bus.dado          = fifo_empty ? '0 : mem_q[rd_ptr_q];
  assign bus.dado_pronto   = !fifo_empty;
  assign bus.ocupado       = (state_q != S_IDLE);
  assign bus.erro_quadro   = erro_quadro_q;
  assign bus.overrun       = overrun_q;
  assign bus.erro_paridade = erro_paridade_q;

endmodule

// File: tb/tb_usart_rx_fifo.sv
// Directed bench for usart_rx_fifo at DATA_W=8, CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_usart_rx_fifo;

  localparam int DW  = 8;
  localparam int CPB = 4;

  logic clk;
  logic rst;
  int   checks;
  int   passed;
  int   fails;

  usart_rx_fifo_if #(.DATA_W(DW)) bus ();

  usart_rx_fifo #(
    .DATA_W      (DW),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives up to nbits bits of a frame (start, data LSB first, [parity], stop), CPB clocks each.
  task automatic send_frame(input logic [7:0] w, input logic stop_b, input logic par_flip, input int nbits);
`ifdef USART_RX_PARIDADE_EN
    logic [10:0] fr;
    fr = {stop_b, (^w) ^ par_flip, w, 1'b0};
`else
    logic [9:0] fr;
    fr = {stop_b, w, 1'b0};
    if (par_flip) fr = {stop_b, w, 1'b0};
`endif
    for (int k = 0; k < $bits(fr); k++) begin
      if (k < nbits) begin
        bus.Rx = fr[k];
        repeat (CPB) @(negedge clk);
      end
    end
    if (nbits >= $bits(fr)) bus.Rx = 1'b1;
  endtask

  task automatic read_word(input string tag, input logic [7:0] exp);
    check({tag, "_pronto"}, 32'(bus.dado_pronto), 32'd1);
    check({tag, "_dado"}, 32'(bus.dado), 32'(exp));
    bus.dado_lido = 1'b1;
    @(negedge clk);
    bus.dado_lido = 1'b0;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    fails  = 0;
    rst           = 1'b1;
    bus.Rx        = 1'b1;
    bus.habilitar = 1'b1;
    bus.dado_lido = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_dado", 32'(bus.dado), 32'd0);
    check("rst_pronto", 32'(bus.dado_pronto), 32'd0);
    check("rst_ocupado", 32'(bus.ocupado), 32'd0);
    check("rst_erro_quadro", 32'(bus.erro_quadro), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    check("rst_erro_paridade", 32'(bus.erro_paridade), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 1: single frame, push one cycle after the stop sample, then pop
    send_frame(8'hA5, 1'b1, 1'b0, 99);
    check("t1_pronto_at_stop", 32'(bus.dado_pronto), 32'd0);
    @(negedge clk);
    check("t1_pronto", 32'(bus.dado_pronto), 32'd1);
    check("t1_dado", 32'(bus.dado), 32'hA5);
    check("t1_erro_quadro", 32'(bus.erro_quadro), 32'd0);
    bus.dado_lido = 1'b1;
    @(negedge clk);
    bus.dado_lido = 1'b0;
    check("t1_pronto_after_pop", 32'(bus.dado_pronto), 32'd0);
    check("t1_dado_after_pop", 32'(bus.dado), 32'd0);

    // 2: one-clock glitch rejected in START
    bus.Rx = 1'b0;
    @(negedge clk);
    bus.Rx = 1'b1;
    repeat (2) @(negedge clk);
    check("t2_ocupado_start", 32'(bus.ocupado), 32'd1);
    repeat (2) @(negedge clk);
    check("t2_ocupado_idle", 32'(bus.ocupado), 32'd0);
    check("t2_erro_quadro", 32'(bus.erro_quadro), 32'd0);
    check("t2_pronto", 32'(bus.dado_pronto), 32'd0);
    repeat (4) @(negedge clk);

    // 3: bad stop bit, then a good frame
    send_frame(8'h3C, 1'b0, 1'b0, 99);
    @(negedge clk);
    check("t3_erro_quadro_pulse", 32'(bus.erro_quadro), 32'd1);
    check("t3_pronto", 32'(bus.dado_pronto), 32'd0);
    @(negedge clk);
    check("t3_erro_quadro_clear", 32'(bus.erro_quadro), 32'd0);
    repeat (8) @(negedge clk);
    send_frame(8'h11, 1'b1, 1'b0, 99);
    @(negedge clk);
    read_word("t3_rd11", 8'h11);
    check("t3_empty", 32'(bus.dado_pronto), 32'd0);

    // 4: overflow is sticky and drops the fifth word
    for (int w = 1; w <= 4; w++) begin
      send_frame(8'(w), 1'b1, 1'b0, 99);
      @(negedge clk);
    end
    check("t4_head", 32'(bus.dado), 32'h01);
    check("t4_overrun_before", 32'(bus.overrun), 32'd0);
    send_frame(8'h05, 1'b1, 1'b0, 99);
    @(negedge clk);
    check("t4_overrun", 32'(bus.overrun), 32'd1);
    read_word("t4_rd1", 8'h01);
    read_word("t4_rd2", 8'h02);
    read_word("t4_rd3", 8'h03);
    read_word("t4_rd4", 8'h04);
    check("t4_empty", 32'(bus.dado_pronto), 32'd0);
    check("t4_empty_dado", 32'(bus.dado), 32'd0);
    check("t4_overrun_sticky", 32'(bus.overrun), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t4_overrun_rst", 32'(bus.overrun), 32'd0);
    repeat (2) @(negedge clk);

    // 5: push and pop in the same cycle while full
    for (int w = 1; w <= 4; w++) begin
      send_frame(8'(w), 1'b1, 1'b0, 99);
      @(negedge clk);
    end
    send_frame(8'h06, 1'b1, 1'b0, 99);
    bus.dado_lido = 1'b1;
    @(negedge clk);
    bus.dado_lido = 1'b0;
    check("t5_overrun", 32'(bus.overrun), 32'd0);
    read_word("t5_rd2", 8'h02);
    read_word("t5_rd3", 8'h03);
    read_word("t5_rd4", 8'h04);
    read_word("t5_rd6", 8'h06);
    check("t5_empty", 32'(bus.dado_pronto), 32'd0);

    // 6: reset in the middle of data bit 3
    send_frame(8'h5A, 1'b1, 1'b0, 99);
    @(negedge clk);
    check("t6_pronto_before", 32'(bus.dado_pronto), 32'd1);
    send_frame(8'h7E, 1'b1, 1'b0, 4);
    bus.Rx = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_ocupado_mid", 32'(bus.ocupado), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_dado", 32'(bus.dado), 32'd0);
    check("t6_rst_pronto", 32'(bus.dado_pronto), 32'd0);
    check("t6_rst_ocupado", 32'(bus.ocupado), 32'd0);
    check("t6_rst_erro_quadro", 32'(bus.erro_quadro), 32'd0);
    check("t6_rst_overrun", 32'(bus.overrun), 32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    send_frame(8'h81, 1'b1, 1'b0, 99);
    @(negedge clk);
    check("t6_erro_paridade_ok", 32'(bus.erro_paridade), 32'd0);
    read_word("t6_rd81", 8'h81);
    check("t6_empty", 32'(bus.dado_pronto), 32'd0);
`ifdef USART_RX_PARIDADE_EN
    repeat (4) @(negedge clk);
    send_frame(8'h81, 1'b1, 1'b1, 99);
    @(negedge clk);
    check("t6_par_pulse", 32'(bus.erro_paridade), 32'd1);
    check("t6_par_no_push", 32'(bus.dado_pronto), 32'd0);
    check("t6_par_quadro", 32'(bus.erro_quadro), 32'd0);
    @(negedge clk);
    check("t6_par_clear", 32'(bus.erro_paridade), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
